// File: rtl/seq_pkg.sv
// Shared types and constants for the event-to-UART reporter.
package seq_pkg;

    // Upper nibble of every framed header byte.
    localparam logic [3:0] SYNC_NIBBLE = 4'hA;

    typedef enum logic {
        RAW    = 1'b0,
        FRAMED = 1'b1
    } report_mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        PAY  = 2'd2,
        CSUM = 2'd3
    } ser_state_e;

    // Number of bytes needed to carry a payload of the given width.
    function automatic int payload_bytes(input int payload_w);
        return (payload_w + 7) / 8;
    endfunction

    // Channel-number field width; never narrower than one bit.
    function automatic int ch_bits(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy output. Push while full and pop while
// empty are ignored, so callers may gate loosely.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (level == (AW+1)'(DEPTH));
    assign empty    = (level == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // Storage array; contents need no reset because level guards reads.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/event_uart_reporter.sv
// Turns rising edges on level-type event sources into byte frames on a
// valid/ready stream: one frame per rising edge, however long the level holds.
// Handshake: a byte transfers on a cycle where tx_valid && tx_ready; once
// tx_valid is high, tx_valid and tx_data hold until that transfer.
module event_uart_reporter
    import seq_pkg::*;
#(
    parameter int NUM_CH     = 2,
    parameter int PAYLOAD_W  = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int MODE       = 1
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic [NUM_CH-1:0]             ev_level,
    input  logic [NUM_CH*PAYLOAD_W-1:0]   ev_data,
    output logic [7:0]                    tx_data,
    output logic                          tx_valid,
    input  logic                          tx_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [7:0]                    drop_count,
    output ser_state_e                    ser_state
);

    localparam int NB      = payload_bytes(PAYLOAD_W);
    localparam int CH_W    = ch_bits(NUM_CH);
    localparam int ENTRY_W = CH_W + PAYLOAD_W;
    localparam int SH_W    = NB * 8;
    localparam int CNT_W   = (NB > 1) ? $clog2(NB) : 1;
    localparam bit FRAMED_MODE = (MODE == int'(FRAMED));

    logic                  armed;
    logic [NUM_CH-1:0]     prev;
    logic [NUM_CH-1:0]     rise;
    logic [NUM_CH-1:0]     pending;
    logic [PAYLOAD_W-1:0]  pay [NUM_CH];
    logic [NUM_CH-1:0]     grant;
    logic [CH_W-1:0]       grant_ch;
    logic [PAYLOAD_W-1:0]  grant_pay;
    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [ENTRY_W-1:0]    fifo_out;
    logic [4:0]            drops;
    logic [8:0]            drop_sum;

    ser_state_e            state;
    ser_state_e            state_next;
    logic [SH_W-1:0]       shift;
    logic [7:0]            csum;
    logic [CH_W-1:0]       hdr_ch;
    logic [CNT_W-1:0]      byte_cnt;

    // Detection stays disarmed for the first cycle after reset so a level
    // already high at release is absorbed into prev instead of firing.
    assign rise = armed ? (ev_level & ~prev) : '0;

    // Edge-detect history and arming.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            armed <= 1'b0;
            prev  <= '0;
        end else begin
            armed <= 1'b1;
            prev  <= ev_level;
        end
    end

    // Fixed-priority arbiter: lowest pending channel goes to the FIFO.
    always_comb begin
        grant     = '0;
        grant_ch  = '0;
        grant_pay = '0;
        fifo_push = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (pending[i] && !fifo_push && !fifo_full) begin
                grant[i]  = 1'b1;
                grant_ch  = CH_W'(i);
                grant_pay = pay[i];
                fifo_push = 1'b1;
            end
        end
    end

    // A rise is lost only when its slot is occupied and not draining now.
    always_comb begin
        drops = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (rise[i] && pending[i] && !grant[i]) drops = drops + 5'd1;
        end
    end

    assign drop_sum = {1'b0, drop_count} + 9'(drops);

    // Per-channel capture slots.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pending <= '0;
            for (int i = 0; i < NUM_CH; i++) pay[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (rise[i] && (!pending[i] || grant[i])) begin
                    pending[i] <= 1'b1;
                    pay[i]     <= ev_data[i*PAYLOAD_W +: PAYLOAD_W];
                end else if (grant[i]) begin
                    pending[i] <= 1'b0;
                end
            end
        end
    end

    // Saturating lost-event counter.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            drop_count <= '0;
        end else begin
            drop_count <= (drop_sum > 9'd255) ? 8'hFF : drop_sum[7:0];
        end
    end

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push      (fifo_push),
        .push_data ({grant_ch, grant_pay}),
        .pop       (fifo_pop),
        .pop_data  (fifo_out),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    // Serializer state register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_next;
    end

    // Serializer next state and byte presentation; valid comes straight from
    // the state so reset drops it without waiting for a clock.
    always_comb begin
        state_next = state;
        fifo_pop   = 1'b0;
        tx_valid   = 1'b0;
        tx_data    = 8'h00;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    state_next = FRAMED_MODE ? HDR : PAY;
                end
            end
            HDR: begin
                tx_valid = 1'b1;
                tx_data  = {SYNC_NIBBLE, 4'(hdr_ch)};
                if (tx_ready) state_next = PAY;
            end
            PAY: begin
                tx_valid = 1'b1;
                tx_data  = shift[SH_W-1 -: 8];
                if (tx_ready && (byte_cnt == CNT_W'(NB-1)))
                    state_next = FRAMED_MODE ? CSUM : IDLE;
            end
            CSUM: begin
                tx_valid = 1'b1;
                tx_data  = csum;
                if (tx_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Serializer datapath: load on pop, advance one byte per payload transfer.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            shift    <= '0;
            csum     <= '0;
            hdr_ch   <= '0;
            byte_cnt <= '0;
        end else begin
            if (fifo_pop) begin
                hdr_ch   <= fifo_out[ENTRY_W-1 -: CH_W];
                shift    <= SH_W'(fifo_out[PAYLOAD_W-1:0]);
                csum     <= FRAMED_MODE ? {SYNC_NIBBLE, 4'(fifo_out[ENTRY_W-1 -: CH_W])} : 8'h00;
                byte_cnt <= '0;
            end else if (state == PAY && tx_ready) begin
                shift    <= shift << 8;
                csum     <= csum ^ shift[SH_W-1 -: 8];
                byte_cnt <= byte_cnt + 1'b1;
            end
        end
    end

    assign ser_state = state;

endmodule

// File: doc/event_uart_reporter.md
# event_uart_reporter

Parametrised event-to-UART bridge for the sequencer. It watches NUM_CH level-type event sources, such as the button matrix `button_pressed` or the rotary-encoder button, and captures a payload once per rising edge. Events queue in a FIFO and leave as byte frames on a valid/ready byte stream that feeds `uart_tx`. It replaces the per-source ad-hoc edge/valid logic in `top` and guarantees one frame per press, however long the level is held.

## Interface
Parameters:
- NUM_CH, 2: number of event channels, 1..16
- PAYLOAD_W, 8: payload bits per channel, 1..32
- FIFO_DEPTH, 4: event FIFO entries, power of two, ≥2
- MODE, 1: 0 = raw (payload bytes only); 1 = framed (header + payload + checksum)

Ports:
- clk  in  1  system clock (12 MHz)
- rstn  in  1  asynchronous, active-low reset
- ev_level  in  NUM_CH  per-channel event level, synchronous to clk
- ev_data  in  NUM_CH*PAYLOAD_W  per-channel payload; channel i occupies bits [i*PAYLOAD_W +: PAYLOAD_W]
- tx_data  out  8  byte to transmitter
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  transmitter can accept a byte
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
- drop_count  out  8  saturating count of lost events

## Operation
- Edge detect: per channel, `prev` register; event = ev_level & ~prev.
  - After reset release, first cycle: `prev` loads ev_level with detection suppressed. A level already high at release produces no event.
- Capture: on event, `pending[i]` sets and `pay[i]` latches ev_data slice.
  - New event while `pending[i]` is already set: the event is discarded and drop_count increments, saturating at 255.
- Arbiter: fixed priority, lowest index first. Moves one pending entry {ch, pay} into the FIFO per cycle, only if the FIFO is not full.
  - FIFO full: pending holds, nothing is lost.
- Payload bytes: NB = ceil(PAYLOAD_W/8). Zero-extend to NB*8 bits and send MSB byte first. Example: PAYLOAD_W=12, 0xABC → 0x0A, 0xBC.
- Framed (MODE=1) frame:
  - Header = {4'hA, ch[3:0]}.
  - Then NB payload bytes.
  - Then checksum = XOR of header and all payload bytes.
- Raw (MODE=0) frame: NB payload bytes only.
- Serializer FSM states: IDLE, HDR, PAY, CSUM.
  - IDLE with FIFO non-empty: pop entry into shift register, go to HDR (MODE=1) or PAY (MODE=0).
  - HDR: on transfer → PAY.
  - PAY: byte counter counts NB transfers, then → CSUM (MODE=1) or IDLE (MODE=0).
  - CSUM: on transfer → IDLE.
- Handshake: transfer occurs on a cycle with tx_valid && tx_ready.
  - tx_valid and tx_data hold stable until transfer.
  - tx_valid never deasserts without a transfer, except on reset.
- Simultaneous edge on a channel and arbiter service of the same channel: the old entry moves to the FIFO and the new event sets pending. No drop.

## Timing
- Reset values (asynchronous):
  - Outputs: tx_valid=0, tx_data=8'h00, fifo_level=0, drop_count=0.
  - Internal: FSM=IDLE; all pending/prev=0; detection disarmed.
- Latency, idle system: rising ev_level sampled at edge N → pending at N+1 → FIFO entry at N+2 → first byte with tx_valid=1 at N+3.
- Byte-to-byte: next byte presented the cycle after a transfer, so one byte per clock at most when tx_ready stays high.
- Back-to-back frames: IDLE costs one cycle between frames.
- Throughput bound: storage = FIFO_DEPTH + 1 (serializer) + NUM_CH (pending).
- Reset asserted mid-frame: frame aborts immediately; tx_valid drops asynchronously. No partial frame resumes after release.

## Structure
- Package `seq_pkg`:
  - `SYNC_NIBBLE = 4'hA`
  - `report_mode_e` (RAW, FRAMED)
  - `ser_state_e` (IDLE, HDR, PAY, CSUM)
  - helper constant for NB
- Sub-module `sync_fifo`:
  - Parametrised width/depth, async active-low reset.
  - Ports: push/pop/full/empty/level.
  - Width = $clog2(NUM_CH) + PAYLOAD_W (min 1-bit ch field).
- Edge detect, pending/arbiter and serializer FSM live in `event_uart_reporter`.

## Test plan
- Config for all scenarios unless stated: NUM_CH=2, PAYLOAD_W=8, FIFO_DEPTH=4, MODE=1, tx_ready=1.
- Single press: ch1 rises with data 0x3C, held 1000 cycles → exactly 3 bytes A1, 3C, 9D; first tx_valid 3 cycles after edge; no further bytes.
- Raw mode: MODE=0, same stimulus → exactly one byte 3C.
- Simultaneous edges: ch0 (0x11) and ch1 (0x22) rise on the same cycle → A0, 11, B1, then A1, 22, 83; drop_count=0.
- Overflow:
  - Stimulus: tx_ready=0; ch0 pulses 8 times with data 0x01..0x08.
  - During stall: fifo_level=4; drop_count=2 (events 0x07, 0x08 lost).
  - After tx_ready=1: exactly 6 frames, payloads 01..06 in order.
- Reset cases:
  - rstn low during PAY byte → tx_valid=0 immediately.
  - ch0 held high across reset release → no frame; next genuine rise → one frame.
- Wide payload: PAYLOAD_W=12, ch0 data 0xABC → A0, 0A, BC, 16.
